// File: rtl/ysyx_220053_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_mem_arbiter_pkg
// Purpose  : Shared definitions for the IF/LS memory arbiter: FSM state
//            encoding, transaction-owner encoding and default bus widths.
// Ports    : none (package)
// Config   : ARB_ROUND_ROBIN_EN (consumed by ysyx_220053_arb_pick)
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_220053_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_220053_mem_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_arb_pick
// Purpose  : Two-input arbiter between instruction fetch and load/store.
//            Grant is purely combinational from the request lines.
//            Default build: fixed priority, LS always beats IF.
//            ARB_ROUND_ROBIN_EN defined: a last_grant register breaks ties
//            in favour of the requester not served last (reset = IF, so LS
//            wins the first tie).
// Ports    : clk, rst        - clock / async active-low reset (RR build only)
//            grant_en_i      - a grant is being taken this cycle (RR only)
//            req_if_i/ls_i   - request lines
//            gnt_if_o/ls_o   - one-hot (or zero) grant
// Config   : ARB_ROUND_ROBIN_EN
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_220053_arb_pick
    import ysyx_220053_mem_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
    input  logic grant_en_i,
`endif
    input  logic req_if_i,
    input  logic req_ls_i,
    output logic gnt_if_o,
    output logic gnt_ls_o
);

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_grant_q;

    // On a tie LS wins only if IF was the one served last.
    assign gnt_ls_o = req_ls_i & (~req_if_i | (last_grant_q == OWN_IF));
    assign gnt_if_o = req_if_i & ~gnt_ls_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= OWN_IF;
        end else if (grant_en_i && (gnt_if_o || gnt_ls_o)) begin
            last_grant_q <= gnt_ls_o ? OWN_LS : OWN_IF;
        end
    end
`else
    assign gnt_ls_o = req_ls_i;
    assign gnt_if_o = req_if_i & ~req_ls_i;
`endif

endmodule
`default_nettype wire

// File: rtl/ysyx_220053_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_220053_mem_arbiter
// Purpose  : Shares one single-ported data memory between instruction fetch
//            (IF, read-only) and load/store (LS). One transaction is in
//            flight at a time: IDLE (arbitrate) -> REQ (present request
//            downstream) -> WAIT (route response back to owner) -> IDLE.
// Ports    : clk / rst                 - clock, async active-low reset
//            if_req_* / if_addr        - IF request channel
//            if_resp_valid / if_rdata  - IF response (1-cycle pulse)
//            ls_req_* / ls_addr/wen/wdata/wmask - LS request channel
//            ls_resp_valid / ls_rdata  - LS response / write ack
//            mem_req_* / mem_addr/wen/wdata/wmask - downstream request
//            mem_resp_valid / mem_rdata - downstream response
// Config   : ARB_ROUND_ROBIN_EN - round-robin tie-break (default: LS first)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_220053_mem_arbiter
    import ysyx_220053_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_resp_valid,
    output logic [DATA_W-1:0]     if_rdata,

    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic                  ls_wen,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_resp_valid,
    output logic [DATA_W-1:0]     ls_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_e                 state_q;
    owner_e                 owner_q;
    logic                   mem_req_valid_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   wen_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W/8-1:0]    wmask_q;

    logic                   w_idle;
    logic                   w_gnt_if;
    logic                   w_gnt_ls;
    logic                   w_resp;

    // Grants are only honoured in IDLE; gating with rst keeps both readies
    // low while reset is held even if a requester is already asserting valid.
    assign w_idle = (state_q == ST_IDLE) & rst;

    ysyx_220053_arb_pick u_arb_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .clk        (clk),
        .rst        (rst),
        .grant_en_i (w_idle),
`endif
        .req_if_i   (if_req_valid),
        .req_ls_i   (ls_req_valid),
        .gnt_if_o   (w_gnt_if),
        .gnt_ls_o   (w_gnt_ls)
    );

    assign if_req_ready = w_idle & w_gnt_if;
    assign ls_req_ready = w_idle & w_gnt_ls;

    // Response pass-through is zero-latency; anything arriving outside WAIT
    // (including a late response for a transaction killed by reset) is dropped.
    assign w_resp        = (state_q == ST_WAIT) & mem_resp_valid;
    assign if_resp_valid = w_resp & (owner_q == OWN_IF);
    assign ls_resp_valid = w_resp & (owner_q == OWN_LS);
    assign if_rdata      = if_resp_valid ? mem_rdata : '0;
    assign ls_rdata      = ls_resp_valid ? mem_rdata : '0;

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_IF;
            mem_req_valid_q <= 1'b0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ls_req_ready) begin
                        addr_q          <= ls_addr;
                        wen_q           <= ls_wen;
                        wdata_q         <= ls_wdata;
                        wmask_q         <= ls_wmask;
                        owner_q         <= OWN_LS;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end else if (if_req_ready) begin
                        // Fetch is always a read: no write data or byte mask.
                        addr_q          <= if_addr;
                        wen_q           <= 1'b0;
                        wdata_q         <= '0;
                        wmask_q         <= '0;
                        owner_q         <= OWN_IF;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_valid_q <= 1'b0;
                    state_q         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220053_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_220053_mem_arbiter
// Purpose  : Directed self-checking bench for ysyx_220053_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_220053_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic [63:0] if_rdata;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_addr;
    logic        ls_wen;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_resp_valid;
    logic [63:0] ls_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    ysyx_220053_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_addr        (ls_addr),
        .ls_wen         (ls_wen),
        .ls_wdata       (ls_wdata),
        .ls_wmask       (ls_wmask),
        .ls_resp_valid  (ls_resp_valid),
        .ls_rdata       (ls_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected owner of each of the four contended grants (1 = LS).
    logic [3:0] exp_ls_win;
    logic       w;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_ls_win = 4'b0101;   // bit t = grant t: LS, IF, LS, IF
`else
        exp_ls_win = 4'b1111;
`endif
        rst = 1'b0;
        if_req_valid = 0; if_addr = '0;
        ls_req_valid = 0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_mem_addr",      mem_addr, 64'd0);
        rst = 1'b1;
        tick();

        // ---- Reset mid-WAIT on an LS read ----
        ls_req_valid = 1; ls_addr = 64'h8000_0010; ls_wen = 0; mem_req_ready = 1;
        #1 chk("rw_ls_ready", {63'd0, ls_req_ready}, 64'd1);
        tick();
        ls_req_valid = 0;
        #1 chk("rw_mem_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("rw_mem_addr", mem_addr, 64'h8000_0010);
        tick();                                    // now in WAIT
        rst = 1'b0;
        #1 chk("rw_rst_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rw_rst_addr",  mem_addr, 64'd0);
        chk("rw_rst_ready", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
        tick();
        rst = 1'b1;
        mem_resp_valid = 1; mem_rdata = 64'h55;
        #1 chk("rw_late_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
        tick();
        mem_resp_valid = 0;

        // ---- Single IF read; IF keeps valid to observe back-pressure ----
        if_req_valid = 1; if_addr = 64'h8000_0000; mem_req_ready = 1;
        #1 chk("if_ready_idle", {63'd0, if_req_ready}, 64'd1);
        tick();                                    // handshake cycle N done
        #1 chk("if_mem_valid_n1", {63'd0, mem_req_valid}, 64'd1);
        chk("if_mem_addr",  mem_addr, 64'h8000_0000);
        chk("if_mem_wen",   {63'd0, mem_wen}, 64'd0);
        chk("if_mem_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("if_bp_req",    {63'd0, if_req_ready}, 64'd0);
        tick();                                    // WAIT at N+2
        mem_resp_valid = 1; mem_rdata = 64'h0000_0013;
        #1 chk("if_resp_valid", {63'd0, if_resp_valid}, 64'd1);
        chk("if_rdata",      if_rdata, 64'h13);
        chk("if_no_ls_resp", {63'd0, ls_resp_valid}, 64'd0);
        chk("if_bp_wait",    {63'd0, if_req_ready}, 64'd0);
        if_req_valid = 0;
        tick();
        mem_resp_valid = 0;
        #1 chk("if_resp_pulse", {63'd0, if_resp_valid}, 64'd0);

        // ---- LS write; fields scrambled after handshake to prove latching ----
        ls_req_valid = 1; ls_addr = 64'h8000_1000; ls_wen = 1;
        ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
        #1 chk("lw_ready", {63'd0, ls_req_ready}, 64'd1);
        tick();
        ls_req_valid = 0; ls_addr = '1; ls_wen = 0; ls_wdata = '1; ls_wmask = '1;
        #1 chk("lw_addr",  mem_addr, 64'h8000_1000);
        chk("lw_wen",   {63'd0, mem_wen}, 64'd1);
        chk("lw_wdata", mem_wdata, 64'hDEAD_BEEF);
        chk("lw_wmask", {56'd0, mem_wmask}, 64'h0F);
        tick();
        mem_resp_valid = 1; mem_rdata = 64'h77;
        #1 chk("lw_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'b01);
        tick();
        mem_resp_valid = 0;
        #1 chk("lw_resp_pulse", {63'd0, ls_resp_valid}, 64'd0);

        // ---- Downstream stall + spurious response in REQ (IF owner) ----
        mem_req_ready = 0;
        if_req_valid = 1; if_addr = 64'h8000_0040;
        #1 chk("st_if_ready", {63'd0, if_req_ready}, 64'd1);
        tick();
        if_req_valid = 0;
        ls_req_valid = 1; ls_addr = 64'h8000_2000; ls_wen = 0;
        for (int i = 0; i < 6; i++) begin
            mem_req_ready  = (i == 5);
            mem_resp_valid = (i == 2);
            #1 chk("st_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("st_addr",  mem_addr, 64'h8000_0040);
            chk("st_no_grant", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
            if (i == 2)
                chk("st_spurious", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
            tick();
        end
        mem_req_ready = 0;
        mem_resp_valid = 1; mem_rdata = 64'hABCD;
        #1 chk("st_route", {62'd0, if_resp_valid, ls_resp_valid}, 64'b10);
        chk("st_rdata", if_rdata, 64'hABCD);
        chk("st_wait_no_grant", {63'd0, ls_req_ready}, 64'd0);
        ls_req_valid = 0;
        tick();
        mem_resp_valid = 0;

        // ---- Four back-to-back contended transactions ----
        mem_req_ready = 1;
        if_req_valid = 1; if_addr = 64'h100;
        ls_req_valid = 1; ls_addr = 64'h200; ls_wen = 0;
        for (int t = 0; t < 4; t++) begin
            w = exp_ls_win[t];
            #1 chk("rr_ls_ready", {63'd0, ls_req_ready}, {63'd0, w});
            chk("rr_if_ready", {63'd0, if_req_ready}, {63'd0, ~w});
            tick();
            #1 chk("rr_addr", mem_addr, w ? 64'h200 : 64'h100);
            tick();
            mem_resp_valid = 1; mem_rdata = 64'(t);
            #1 chk("rr_resp", {62'd0, if_resp_valid, ls_resp_valid}, w ? 64'b01 : 64'b10);
            tick();
            mem_resp_valid = 0;
        end
        if_req_valid = 0; ls_req_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ysyx_220053_mem_arbiter.md
# ysyx_220053_mem_arbiter

Two-requester memory arbiter sharing the single-ported data memory between instruction fetch (IF) and load/store (LS) once the core moves from single-cycle to multi-cycle execution. Accepts one request at a time over valid/ready, forwards it to the downstream memory port, waits for the response, and routes it back to the owning requester. Exactly one transaction is outstanding at any time.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; wmask width is DATA_W/8

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  IF request present
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  ADDR_W  IF read address
- if_resp_valid  out  1  IF read data valid (one-cycle pulse)
- if_rdata  out  DATA_W  IF read data
- ls_req_valid  in  1  LS request present
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  ADDR_W  LS address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  DATA_W  write data
- ls_wmask  in  DATA_W/8  byte write mask
- ls_resp_valid  out  1  LS read data / write ack (one-cycle pulse)
- ls_rdata  out  DATA_W  LS read data (undefined on write ack)
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_resp_valid  in  1  downstream response
- mem_rdata  in  DATA_W  downstream read data

## Operation
- States: IDLE, REQ, WAIT. Owner register: IF or LS.
- IDLE: pick winner among valid requesters; assert only winner's *_req_ready (combinational from valid + arbitration). On handshake: latch addr/wen/wdata/wmask (IF forces wen=0, wmask=0), set owner, go to REQ.
- REQ: mem_req_valid=1, fields held stable; on mem_req_ready go to WAIT.
- WAIT: on mem_resp_valid drive owner's *_resp_valid=1 and *_rdata=mem_rdata combinationally in the same cycle; go to IDLE. Non-owner resp_valid stays 0.
- Both *_req_ready are 0 in REQ and WAIT; mem_resp_valid outside WAIT is ignored.
- Requester must hold valid and fields until ready; arbiter does not buffer a second request.
- Reset (any state): state=IDLE, owner=IF, all outputs 0, latched fields 0; an in-flight transaction is abandoned, its late response ignored.

## Timing
- Request handshake (cycle N) -> mem_req_valid at N+1.
- mem_req_ready at cycle M -> WAIT from M+1; response pass-through 0 cycles.
- Response at cycle R -> IDLE at R+1; next grant possible at R+1.
- Minimum transaction with ready memory and next-cycle response: 3 cycles, back-to-back throughput one transaction per 3 cycles.
- Arbitration decision is made only in IDLE; priority state updates on each grant.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin; last_grant register (reset = IF, so LS wins first simultaneous request); on simultaneous requests grant the requester not granted last.
- Undefined: fixed priority, LS always wins over IF (guarantees load/store progress in the multi-cycle core); no last_grant register.

## Structure
- Shared package: state encoding (IDLE/REQ/WAIT), owner encoding (OWN_IF=0, OWN_LS=1), ADDR_W/DATA_W defaults.
- One sub-module natural: ysyx_220053_arb_pick (two-input arbiter, combinational grant + optional last_grant register under the macro).

## Test plan
- Reset mid-WAIT: LS read 0x80000010 in WAIT, pull rst low -> all outputs 0, state IDLE; a subsequent mem_resp_valid produces no ls_resp_valid.
- Single IF read: if_addr=0x80000000, memory ready, responds next cycle with 0x00000013 -> mem_req_valid at N+1, if_resp_valid pulse with if_rdata=0x00000013 at N+2, IF back-pressured throughout.
- LS write: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F -> mem fields match exactly, ls_resp_valid one pulse, if_resp_valid stays 0.
- Downstream stall: mem_req_ready low 5 cycles -> mem_req_valid and fields held stable 6 cycles, no new grants.
- Simultaneous requests for 4 transactions: fixed priority -> LS,LS,LS,LS while LS keeps requesting; with ARB_ROUND_ROBIN_EN -> LS,IF,LS,IF.
- Response routing: IF owner, spurious mem_resp_valid in REQ -> ignored; real response in WAIT -> only if_resp_valid pulses.
